// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage beq/bne resolution with branch-operand hazard stalls.
// Latency: redirect (pc_src/ifid_flush/pc_target) is combinational on the resolve
//   cycle. A dependent branch first stalls for 1 or 2 cycles (EX ALU / EX load).
// Backpressure: pc_write/ifid_write low plus idex_bubble high while a branch operand
//   is still in flight. The branch is then evaluated with forwarded operands.
// Optional feature: define BRANCH_STATS_EN to add saturating counters
//   stat_branches/stat_taken/stat_stalls (CNT_W bits each).
// Ports: clk/rst_n (async active-low); ID branch decode + operands; EX/MEM/WB
//   forwarding data and hazard info; PC/IF-ID/ID-EX control and redirect target out.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_beq,
  input  logic              id_bne,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_wdata,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic              exmem_memread,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] br_target,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_stalls
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              branch;
  logic              dep_ex;
  logic              dep_mem;
  logic [1:0]        need;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              taken;
  logic              stall;
  logic              resolve;

  // CNT_W only sizes the statistics counters; a non-positive width makes no sense.
  if (CNT_W < 1) begin : g_bad_cnt_w
  end

  // $0 is never a real dependency: writes to it are discarded.
  function automatic logic dep(input logic [REG_W-1:0] x,
                               input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt);
    return (x != '0) && ((x == rs) || (x == rt));
  endfunction

  assign branch  = id_beq | id_bne;
  assign dep_ex  = dep(idex_rd, id_rs, id_rt);
  assign dep_mem = dep(exmem_rd, id_rs, id_rt);

  // Stall depth: a load in EX needs two cycles before its data reaches MEM/WB,
  // an ALU result in EX or a load in MEM needs one.
  always_comb begin
    need = 2'd0;
    if (idex_memread && idex_regwrite && dep_ex) begin
      need = 2'd2;
    end else if (idex_regwrite && dep_ex) begin
      need = 2'd1;
    end else if (exmem_memread && dep_mem) begin
      need = 2'd1;
    end
  end

  // Operand select; 2'b11 falls back to the register file.
  always_comb begin
    case (fwd_a)
      2'b10:   op_a = exmem_result;
      2'b01:   op_a = memwb_wdata;
      default: op_a = id_rs_data;
    endcase
    case (fwd_b)
      2'b10:   op_b = exmem_result;
      2'b01:   op_b = memwb_wdata;
      default: op_b = id_rt_data;
    endcase
  end

  // beq wins when both decode bits are set.
  assign taken = (id_beq & (op_a == op_b)) |
                 (~id_beq & id_bne & (op_a != op_b));

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    resolve = 1'b0;
    case (state_q)
      RUN: begin
        if (branch) begin
          if (need != 2'd0) begin
            stall   = 1'b1;
            state_d = (need == 2'd2) ? HOLD : RESOLVE;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      HOLD: begin
        // Second stall cycle completes even if the branch has vanished.
        stall   = 1'b1;
        state_d = RESOLVE;
      end
      RESOLVE: begin
        // Hazard inputs are ignored here: the producer has moved on and the
        // forwarding selects now point at it.
        resolve = branch;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  assign pc_src      = resolve & taken;
  assign ifid_flush  = pc_src;
  assign pc_target   = resolve ? br_target : '0;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  // Saturating increments: hold at all-ones instead of wrapping.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    st_cnt_d = st_cnt_q;
    if (resolve && !(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (pc_src  && !(&tk_cnt_q)) tk_cnt_d = tk_cnt_q + CNT_W'(1);
    if (stall   && !(&st_cnt_q)) st_cnt_d = st_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_taken    = tk_cnt_q;
  assign stat_stalls   = st_cnt_q;
`endif

endmodule
